// File: rtl/design_params_pkg.sv
// Shared parameters for the timer peripheral and its bus arbiter.
// Address map constants are the timer register offsets seen on the slave port.
package design_params_pkg;

   localparam int P_ADDR_WIDTH  = 8;
   localparam int P_DATA_WIDTH  = 32;
   localparam int P_ARB_TIMEOUT = 16;

   localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_LOAD   = 8'h04;
   localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_STATUS = 8'h0C;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/timer_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping modulo N.
module rr_priority_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 any_req
);

   localparam int IW = $clog2(N);

   int idx;

   always_comb begin
      grant_idx = '0;
      any_req   = 1'b0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any_req && req[idx]) begin
            any_req   = 1'b1;
            grant_idx = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing one timer slave port between N masters; one
// transaction in flight, request fields held stable, hung slave aborted by timeout.
module timer_bus_arbiter
   import design_params_pkg::*;
#(
   parameter int N_MASTERS   = 2,
   parameter int ADDR_WIDTH  = P_ADDR_WIDTH,
   parameter int DATA_WIDTH  = P_DATA_WIDTH,
   parameter int TIMEOUT_CYC = P_ARB_TIMEOUT
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [N_MASTERS-1:0]                  m_req,
   input  logic [N_MASTERS-1:0]                  m_write_en,
   input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr,
   input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata,
   output logic [N_MASTERS-1:0]                  m_gnt,
   output logic [DATA_WIDTH-1:0]                 m_rdata,
   output logic                                  m_err,
   output logic                                  s_req,
   output logic                                  s_write_en,
   output logic [ADDR_WIDTH-1:0]                 s_addr,
   output logic [DATA_WIDTH-1:0]                 s_wdata,
   input  logic                                  s_gnt,
   input  logic [DATA_WIDTH-1:0]                 s_rdata,
   output logic                                  busy,
   output logic [$clog2(N_MASTERS)-1:0]          owner,
   output logic [1:0]                            state_dbg
);

   localparam int IW = $clog2(N_MASTERS);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] ST_IDLE    = ARB_IDLE;
   localparam logic [1:0] ST_ISSUE   = ARB_ISSUE;
   localparam logic [1:0] ST_RELEASE = ARB_RELEASE;

   logic [1:0]            state_q, state_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
   logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
   logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
   logic                  s_we_q, s_we_d;

   logic [IW-1:0] pick_idx;
   logic          any_req;
   logic          in_issue;
   logic          tmo_hit;
   logic          done;
   logic [IW-1:0] next_ptr;

   rr_priority_pick #(.N(N_MASTERS)) u_pick (
      .req       (m_req),
      .ptr       (rr_ptr_q),
      .grant_idx (pick_idx),
      .any_req   (any_req)
   );

   assign in_issue = (state_q == ST_ISSUE);
   assign tmo_hit  = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
   // s_gnt has priority over a timeout landing in the same cycle.
   assign done     = in_issue && (s_gnt || tmo_hit);
   assign next_ptr = (owner_q == IW'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      tmo_cnt_d = tmo_cnt_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_we_d    = s_we_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d   = pick_idx;
               s_addr_d  = m_addr[pick_idx];
               s_wdata_d = m_wdata[pick_idx];
               s_we_d    = m_write_en[pick_idx];
               tmo_cnt_d = '0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (done) begin
               rr_ptr_d = next_ptr;
               state_d  = ST_RELEASE;
            end else if (tmo_cnt_q != TW'(TIMEOUT_CYC)) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         tmo_cnt_q <= '0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_we_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         tmo_cnt_q <= tmo_cnt_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_we_q    <= s_we_d;
      end
   end

   // Completion is combinational off s_gnt so the owner sees it with no added latency.
   always_comb begin
      m_gnt   = '0;
      m_rdata = '0;
      m_err   = 1'b0;
      if (done) begin
         m_gnt[owner_q] = 1'b1;
         m_err          = !s_gnt;
         if (s_gnt && !s_we_q) m_rdata = s_rdata;
      end
   end

   assign s_req      = in_issue;
   assign s_write_en = s_we_q;
   assign s_addr     = s_addr_q;
   assign s_wdata    = s_wdata_q;
   assign busy       = (state_q != ST_IDLE);
   assign owner      = owner_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: two master drivers, a stub timer slave, and a
// scoreboard monitor that checks every m_gnt against per-master expected queues.
`timescale 1ns/1ps
module tb_timer_bus_arbiter;
   import design_params_pkg::*;

   localparam int N  = 2;
   localparam int AW = P_ADDR_WIDTH;
   localparam int DW = P_DATA_WIDTH;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [5:0]    len;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]          m_req;
   logic [N-1:0]          m_write_en;
   logic [N-1:0][AW-1:0]  m_addr;
   logic [N-1:0][DW-1:0]  m_wdata;
   logic [N-1:0]          m_gnt;
   logic [DW-1:0]         m_rdata;
   logic                  m_err;
   logic                  s_req;
   logic                  s_write_en;
   logic [AW-1:0]         s_addr;
   logic [DW-1:0]         s_wdata;
   logic                  s_gnt;
   logic [DW-1:0]         s_rdata;
   logic                  busy;
   logic [0:0]            owner;
   logic [1:0]            state_dbg;

   timer_bus_arbiter #(
      .N_MASTERS   (N),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .m_req      (m_req),
      .m_write_en (m_write_en),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_gnt      (m_gnt),
      .m_rdata    (m_rdata),
      .m_err      (m_err),
      .s_req      (s_req),
      .s_write_en (s_write_en),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_gnt      (s_gnt),
      .s_rdata    (s_rdata),
      .busy       (busy),
      .owner      (owner),
      .state_dbg  (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;

   txn_t       txq0[$];
   txn_t       txq1[$];
   exp_t       exp0_q[$];
   exp_t       exp1_q[$];
   logic [0:0] exp_own_q[$];
   bit   [1:0] done_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- stub timer slave ----------------
   logic [DW-1:0] mem [0:255];
   logic          status_q;
   bit            slave_hang;
   int            slave_lat;
   int            lat_cnt;

   always @(negedge clk) begin
      if (!reset_n) begin
         s_gnt   = 1'b0;
         s_rdata = '0;
         lat_cnt = 0;
      end else if (s_gnt) begin
         s_gnt   = 1'b0;
         s_rdata = '0;
         lat_cnt = 0;
      end else if (s_req && !slave_hang) begin
         if (lat_cnt == slave_lat) begin
            s_gnt   = 1'b1;
            lat_cnt = 0;
            if (s_write_en) begin
               mem[s_addr] = s_wdata;
               s_rdata     = 32'hDEAD_BEEF;
            end else if (s_addr == P_ADDR_STATUS) begin
               s_rdata  = {31'd0, status_q};
               status_q = 1'b0;
            end else begin
               s_rdata = mem[s_addr];
            end
         end else begin
            lat_cnt++;
         end
      end else begin
         lat_cnt = 0;
      end
   end

   // ---------------- master drivers ----------------
   txn_t drv_t;
   always @(negedge clk) begin
      if (done_m[0]) begin m_req[0] = 1'b0; done_m[0] = 1'b0; end
      if (done_m[1]) begin m_req[1] = 1'b0; done_m[1] = 1'b0; end
      if (reset_n && !m_req[0] && txq0.size() > 0) begin
         drv_t = txq0.pop_front();
         m_write_en[0] = drv_t.we;
         m_addr[0]     = drv_t.addr;
         m_wdata[0]    = drv_t.wdata;
         m_req[0]      = 1'b1;
      end
      if (reset_n && !m_req[1] && txq1.size() > 0) begin
         drv_t = txq1.pop_front();
         m_write_en[1] = drv_t.we;
         m_addr[1]     = drv_t.addr;
         m_wdata[1]    = drv_t.wdata;
         m_req[1]      = 1'b1;
      end
   end

   task automatic send(input int m, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                       input logic exp_err, input int exp_len);
      txn_t t;
      exp_t e;
      t.we = we; t.addr = addr; t.wdata = wdata;
      e.rdata = exp_rdata; e.err = exp_err; e.we = we; e.addr = addr;
      e.wdata = wdata; e.len = 6'(exp_len);
      if (m == 0) begin txq0.push_back(t); exp0_q.push_back(e); end
      else        begin txq1.push_back(t); exp1_q.push_back(e); end
   endtask

   // ---------------- monitor ----------------
   int   cyc = 0;
   int   last_gnt = -100;
   int   issue_len = 0;
   bit   post1, post2;
   exp_t mon_e;
   int   mon_m;

   always @(negedge clk) begin
      #2;
      cyc++;
      if (!reset_n) begin
         issue_len = 0;
         last_gnt  = -100;
         post1     = 1'b0;
         post2     = 1'b0;
      end else begin
         if (s_req) issue_len++; else issue_len = 0;
         if (post2) begin
            post2 = 1'b0;
            check("idle_after_release", 64'(state_dbg), 64'(ARB_IDLE));
         end
         if (post1) begin
            post1 = 1'b0;
            post2 = 1'b1;
            check("release_cycle", 64'({s_req, m_gnt, m_err, state_dbg}),
                  64'({1'b0, 2'b00, 1'b0, 2'(ARB_RELEASE)}));
         end
         if (m_gnt == '0 && m_err) check("err_without_gnt", 64'(m_err), 64'(0));
         if (m_gnt != '0) begin
            check("gnt_onehot", 64'($countones(m_gnt)), 64'(1));
            mon_m = m_gnt[1] ? 1 : 0;
            check("owner_matches_gnt", 64'(owner), 64'(mon_m));
            if ((mon_m == 0 && exp0_q.size() == 0) || (mon_m == 1 && exp1_q.size() == 0)) begin
               check("unexpected_gnt", 64'(mon_m), 64'(2));
            end else begin
               mon_e = (mon_m == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
               check("rdata",      64'(m_rdata),    64'(mon_e.rdata));
               check("err",        64'(m_err),      64'(mon_e.err));
               check("s_addr",     64'(s_addr),     64'(mon_e.addr));
               check("s_write_en", 64'(s_write_en), 64'(mon_e.we));
               check("s_wdata",    64'(s_wdata),    64'(mon_e.wdata));
               check("issue_len",  64'(issue_len),  64'(mon_e.len));
            end
            if (exp_own_q.size() > 0) check("owner_order", 64'(mon_m), 64'(exp_own_q.pop_front()));
            check("gnt_spacing_ge3", 64'((cyc - last_gnt) >= 3), 64'(1));
            last_gnt      = cyc;
            post1         = 1'b1;
            done_m[mon_m] = 1'b1;
         end
      end
   end

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp0_q.size() != 0 || exp1_q.size() != 0 || txq0.size() != 0 ||
              txq1.size() != 0 || busy || m_req != '0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, 64'(n < 400), 64'(1));
      if (n >= 400) begin
         txq0.delete(); txq1.delete(); exp0_q.delete(); exp1_q.delete(); exp_own_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset_n    = 1'b0;
      m_req      = '0;
      m_write_en = '0;
      m_addr     = '0;
      m_wdata    = '0;
      s_gnt      = 1'b0;
      s_rdata    = '0;
      done_m     = '0;
      slave_hang = 1'b0;
      slave_lat  = 2;
      status_q   = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = '0;

      repeat (3) @(negedge clk);
      check("rst_outputs", 64'({s_req, s_write_en, m_gnt, m_err, busy, owner, state_dbg}), 64'(0));
      check("rst_s_addr",  64'(s_addr),  64'(0));
      check("rst_s_wdata", 64'(s_wdata), 64'(0));
      check("rst_m_rdata", 64'(m_rdata), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // simultaneous requests from reset: M0 first, then M1
      @(posedge clk);
      exp_own_q.push_back(1'b0); exp_own_q.push_back(1'b1);
      send(0, 1'b0, P_ADDR_LOAD,   32'h0, 32'h0, 1'b0, 3);
      send(1, 1'b0, P_ADDR_STATUS, 32'h0, 32'h0, 1'b0, 3);
      wait_drain("t2");

      // write LOAD then read it back from both masters
      send(0, 1'b1, P_ADDR_LOAD, 32'h0000_0010, 32'h0, 1'b0, 3);
      wait_drain("t1a");
      send(0, 1'b0, P_ADDR_LOAD, 32'h1234_5678, 32'h0000_0010, 1'b0, 3);
      wait_drain("t1b");
      send(1, 1'b0, P_ADDR_LOAD, 32'h0, 32'h0000_0010, 1'b0, 3);
      wait_drain("t1c");

      // continuous contention: strict alternation 0,1,0,1,0,1
      @(posedge clk);
      for (int i = 0; i < 6; i++) exp_own_q.push_back(1'(i % 2));
      send(0, 1'b1, 8'h20, 32'hA5A5_0001, 32'h0,         1'b0, 3);
      send(0, 1'b0, 8'h21, 32'h0,         32'h5A5A_0002, 1'b0, 3);
      send(0, 1'b1, 8'h22, 32'h0000_0003, 32'h0,         1'b0, 3);
      send(1, 1'b1, 8'h21, 32'h5A5A_0002, 32'h0,         1'b0, 3);
      send(1, 1'b0, 8'h20, 32'h0,         32'hA5A5_0001, 1'b0, 3);
      send(1, 1'b0, 8'h22, 32'h0,         32'h0000_0003, 1'b0, 3);
      wait_drain("t3");

      // s_gnt on the last allowed cycle beats the timeout
      slave_lat = 15;
      send(0, 1'b0, P_ADDR_LOAD, 32'h0, 32'h0000_0010, 1'b0, 16);
      wait_drain("gnt_vs_tmo");
      slave_lat = 2;

      // hung slave: aborted after 16 issue cycles, then normal service
      slave_hang = 1'b1;
      send(1, 1'b0, P_ADDR_LOAD, 32'h0, 32'h0, 1'b1, 16);
      wait_drain("t4a");
      slave_hang = 1'b0;
      send(0, 1'b0, P_ADDR_LOAD, 32'h0, 32'h0000_0010, 1'b0, 3);
      wait_drain("t4b");

      // status after expiry, cleared by the read
      status_q = 1'b1;
      send(1, 1'b0, P_ADDR_STATUS, 32'h0, 32'h0000_0001, 1'b0, 3);
      wait_drain("t5a");
      send(1, 1'b0, P_ADDR_STATUS, 32'h0, 32'h0, 1'b0, 3);
      wait_drain("t5b");
      send(0, 1'b1, 8'h23, 32'h0000_0077, 32'h0, 1'b0, 3);
      wait_drain("t5c");

      // reset while issuing: outputs drop at once, rr pointer back to 0
      slave_hang = 1'b1;
      send(1, 1'b0, P_ADDR_LOAD, 32'h0, 32'h0, 1'b0, 3);
      n = 0;
      while (!s_req && n < 50) begin @(negedge clk); n++; end
      check("t6_reach_issue", 64'(s_req), 64'(1));
      repeat (4) @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("t6_async_rst", 64'({s_req, m_gnt, m_err, busy, owner, state_dbg}), 64'(0));
      txq0.delete(); txq1.delete(); exp0_q.delete(); exp1_q.delete(); exp_own_q.delete();
      m_req      = '0;
      done_m     = '0;
      slave_hang = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      @(posedge clk);
      exp_own_q.push_back(1'b0); exp_own_q.push_back(1'b1);
      send(0, 1'b0, 8'h23, 32'h0, 32'h0000_0077, 1'b0, 3);
      send(1, 1'b0, 8'h20, 32'h0, 32'hA5A5_0001, 1'b0, 3);
      wait_drain("t6_after");

      check("leftover_expect", 64'(exp0_q.size() + exp1_q.size() + exp_own_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
